vga_pic_window: RTL and testbench



---
 rtl/vga_pic_window.sv | 195 +++++++++++++++++++
 tb/tb_vga_pic_window.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pic_window.sv
// VGA timing generator with a movable PIC_W x PIC_H image window read from an external ROM.
// The window moves on key pulses (manual) or bounces between the screen edges (auto).
module vga_pic_window #(
  parameter int               H_ACTIVE = 800,
  parameter int               H_FP     = 40,
  parameter int               H_SYNC   = 128,
  parameter int               H_BP     = 88,
  parameter int               V_ACTIVE = 600,
  parameter int               V_FP     = 1,
  parameter int               V_SYNC   = 4,
  parameter int               V_BP     = 23,
  parameter logic             SYNC_POL = 1'b1,
  parameter int               PIC_W    = 256,
  parameter int               PIC_H    = 256,
  parameter int               ADDR_W   = 16,
  parameter int               RGB_W    = 8,
  parameter int               ROM_LAT  = 1,
  parameter int               STEP     = 8,
  parameter logic [RGB_W-1:0] BG_COLOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        key_pulse,
  input  logic              mode_toggle,
  input  logic [RGB_W-1:0]  rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [RGB_W-1:0]  vga_rgb,
  output logic              frame_start
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int XW     = $clog2(H_ACTIVE + 1);
  localparam int YW     = $clog2(V_ACTIVE + 1);
  localparam int DLY    = ROM_LAT + 1;
  localparam int X_MAX  = H_ACTIVE - PIC_W;
  localparam int Y_MAX  = V_ACTIVE - PIC_H;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  typedef enum logic {MODE_MANUAL, MODE_AUTO} mode_t;

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          h_last, v_last, frame_end;

  assign h_last      = (h_cnt_reg == HW'(H_TOT - 1));
  assign v_last      = (v_cnt_reg == VW'(V_TOT - 1));
  assign frame_end   = h_last && v_last;
  assign frame_start = frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_last ? '0 : h_cnt_reg + 1'b1;
      if (h_last)
        v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
    end
  end

  // Window position and mode state
  mode_t         mode_reg, mode_next;
  logic [XW-1:0] x0_reg, x0_next;
  logic [YW-1:0] y0_reg, y0_next;
  logic          dir_x_reg, dir_x_next, dir_y_reg, dir_y_next;
  logic [3:0]    pend_key_reg, pend_key_next, keys_eff;
  logic          pend_tog_reg, pend_tog_next, tog_eff;

  logic [31:0] h_w, v_w, x_w, y_w;
  assign h_w = 32'(h_cnt_reg);
  assign v_w = 32'(v_cnt_reg);
  assign x_w = 32'(x0_reg);
  assign y_w = 32'(y0_reg);

  always_comb begin
    keys_eff      = pend_key_reg | key_pulse;
    tog_eff       = pend_tog_reg | mode_toggle;
    pend_key_next = keys_eff;
    pend_tog_next = tog_eff;
    mode_next     = mode_reg;
    x0_next       = x0_reg;
    y0_next       = y0_reg;
    dir_x_next    = dir_x_reg;
    dir_y_next    = dir_y_reg;
    if (frame_end) begin
      pend_key_next = '0;
      pend_tog_next = 1'b0;
      if (tog_eff)
        mode_next = (mode_reg == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
      if (mode_reg == MODE_AUTO) begin
        // Landing on a limit holds it for this frame and reverses for the next
        if (dir_x_reg) begin
          if (x_w + 1 >= X_MAX) begin
            x0_next    = XW'(X_MAX);
            dir_x_next = 1'b0;
          end else x0_next = XW'(x_w + 1);
        end else begin
          if (x_w <= 1) begin
            x0_next    = '0;
            dir_x_next = 1'b1;
          end else x0_next = XW'(x_w - 1);
        end
        if (dir_y_reg) begin
          if (y_w + 1 >= Y_MAX) begin
            y0_next    = YW'(Y_MAX);
            dir_y_next = 1'b0;
          end else y0_next = YW'(y_w + 1);
        end else begin
          if (y_w <= 1) begin
            y0_next    = '0;
            dir_y_next = 1'b1;
          end else y0_next = YW'(y_w - 1);
        end
      end else begin
        if (keys_eff[3] && !keys_eff[2])
          x0_next = (x_w + STEP >= X_MAX) ? XW'(X_MAX) : XW'(x_w + STEP);
        else if (keys_eff[2] && !keys_eff[3])
          x0_next = (x_w <= STEP) ? '0 : XW'(x_w - STEP);
        if (keys_eff[1] && !keys_eff[0])
          y0_next = (y_w + STEP >= Y_MAX) ? YW'(Y_MAX) : YW'(y_w + STEP);
        else if (keys_eff[0] && !keys_eff[1])
          y0_next = (y_w <= STEP) ? '0 : YW'(y_w - STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg     <= MODE_MANUAL;
      x0_reg       <= XW'(X_MAX / 2);
      y0_reg       <= YW'(Y_MAX / 2);
      dir_x_reg    <= 1'b1;
      dir_y_reg    <= 1'b1;
      pend_key_reg <= '0;
      pend_tog_reg <= 1'b0;
    end else begin
      mode_reg     <= mode_next;
      x0_reg       <= x0_next;
      y0_reg       <= y0_next;
      dir_x_reg    <= dir_x_next;
      dir_y_reg    <= dir_y_next;
      pend_key_reg <= pend_key_next;
      pend_tog_reg <= pend_tog_next;
    end
  end

  // Raw per-sample flags and ROM address
  logic de_raw, hs_raw, vs_raw, in_win;
  logic [ADDR_W-1:0] addr_calc;

  assign de_raw = (h_w < H_ACTIVE) && (v_w < V_ACTIVE);
  assign hs_raw = (h_w >= HS_BEG) && (h_w < HS_END);
  assign vs_raw = (v_w >= VS_BEG) && (v_w < VS_END);
  assign in_win = (h_w >= x_w) && (h_w < x_w + PIC_W) &&
                  (v_w >= y_w) && (v_w < y_w + PIC_H);
  // Modular arithmetic in ADDR_W bits yields the truncated address directly
  assign addr_calc = (ADDR_W'(v_cnt_reg) - ADDR_W'(y0_reg)) * ADDR_W'(PIC_W)
                   + (ADDR_W'(h_cnt_reg) - ADDR_W'(x0_reg));

  logic [DLY-1:0] de_sr, win_sr, hs_sr, vs_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      de_sr    <= '0;
      win_sr   <= '0;
      hs_sr    <= {DLY{~SYNC_POL}};
      vs_sr    <= {DLY{~SYNC_POL}};
      vga_hs   <= ~SYNC_POL;
      vga_vs   <= ~SYNC_POL;
      vga_de   <= 1'b0;
      vga_rgb  <= '0;
    end else begin
      rom_addr <= in_win ? addr_calc : '0;
      de_sr    <= {de_sr[DLY-2:0], de_raw};
      win_sr   <= {win_sr[DLY-2:0], in_win};
      hs_sr    <= {hs_sr[DLY-2:0], hs_raw ? SYNC_POL : ~SYNC_POL};
      vs_sr    <= {vs_sr[DLY-2:0], vs_raw ? SYNC_POL : ~SYNC_POL};
      vga_hs   <= hs_sr[DLY-1];
      vga_vs   <= vs_sr[DLY-1];
      vga_de   <= de_sr[DLY-1];
      vga_rgb  <= de_sr[DLY-1] ? (win_sr[DLY-1] ? rom_q : BG_COLOR) : '0;
    end
  end

endmodule

// File: tb/tb_vga_pic_window.sv
// Randomised bench for vga_pic_window: two instances (ROM latency 1 and 3, opposite sync
// polarity) on a reduced screen, checked every cycle against a behavioural screen model.
module tb_vga_pic_window;

  localparam int HA = 24, HF = 2, HS = 3, HB = 3;
  localparam int VA = 16, VF = 1, VS = 2, VB = 1;
  localparam int PW = 8, PH = 4, AW = 8, RW = 8, STEP = 3;
  localparam logic [7:0] BG = 8'hA5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int XMAX = HA - PW, YMAX = VA - PH;
  localparam int LAT_A = 1, LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] key_pulse = 4'h0;
  logic mode_toggle = 1'b0;

  logic [RW-1:0] rom_q_a, rom_q_b, rgb_a, rgb_b;
  logic [AW-1:0] addr_a, addr_b;
  logic hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;

  vga_pic_window #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .PIC_W(PW), .PIC_H(PH), .ADDR_W(AW), .RGB_W(RW),
    .ROM_LAT(LAT_A), .STEP(STEP), .BG_COLOR(BG)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .mode_toggle(mode_toggle),
    .rom_q(rom_q_a), .rom_addr(addr_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .vga_de(de_a), .vga_rgb(rgb_a), .frame_start(fs_a)
  );

  vga_pic_window #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .PIC_W(PW), .PIC_H(PH), .ADDR_W(AW), .RGB_W(RW),
    .ROM_LAT(LAT_B), .STEP(STEP), .BG_COLOR(BG)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .mode_toggle(mode_toggle),
    .rom_q(rom_q_b), .rom_addr(addr_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .vga_de(de_b), .vga_rgb(rgb_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  // ROM models: data equals the low address byte, delayed by the configured latency
  logic [AW-1:0] pipe_a [0:3];
  logic [AW-1:0] pipe_b [0:3];
  always @(posedge clk) begin
    pipe_a[0] <= addr_a;
    pipe_b[0] <= addr_b;
    for (int i = 1; i < 4; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign rom_q_a = pipe_a[LAT_A-1];
  assign rom_q_b = pipe_b[LAT_B-1];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the screen
  typedef struct {bit de; bit hs; bit vs; bit win; int addr;} samp_t;
  samp_t q_a[$];
  samp_t q_b[$];
  int m_h, m_v, m_x, m_y, m_dx, m_dy, exp_addr;
  bit m_auto, m_tog;
  bit [3:0] m_keys;

  function automatic logic [19:0] pack(logic fs, logic hs, logic vs, logic de,
                                       logic [7:0] rgb, logic [7:0] addr);
    return {fs, hs, vs, de, rgb, addr};
  endfunction

  function automatic logic [7:0] exp_rgb(samp_t s);
    if (!s.de) return 8'h00;
    if (s.win) return 8'(s.addr);
    return BG;
  endfunction

  task automatic model_reset();
    samp_t z;
    z = '{de: 0, hs: 0, vs: 0, win: 0, addr: 0};
    m_h = 0; m_v = 0; m_x = XMAX / 2; m_y = YMAX / 2; m_dx = 1; m_dy = 1;
    m_auto = 0; m_tog = 0; m_keys = 4'h0; exp_addr = 0;
    q_a.delete(); q_b.delete();
    for (int i = 0; i < 2 + LAT_A; i++) q_a.push_back(z);
    for (int i = 0; i < 2 + LAT_B; i++) q_b.push_back(z);
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Compare process
  initial begin
    samp_t sa, sb, cur;
    bit bnd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        check("reset_a", pack(fs_a, hs_a, vs_a, de_a, rgb_a, addr_a), pack(0, 0, 0, 0, 8'h00, 8'h00));
        check("reset_b", pack(fs_b, hs_b, vs_b, de_b, rgb_b, addr_b), pack(0, 1, 1, 0, 8'h00, 8'h00));
      end else begin
        bnd = (m_h == HT - 1) && (m_v == VT - 1);
        sa = q_a.pop_front();
        sb = q_b.pop_front();
        check("outputs_a", pack(fs_a, hs_a, vs_a, de_a, rgb_a, addr_a),
              pack(bnd, sa.hs, sa.vs, sa.de, exp_rgb(sa), 8'(exp_addr)));
        check("outputs_b", pack(fs_b, hs_b, vs_b, de_b, rgb_b, addr_b),
              pack(bnd, !sb.hs, !sb.vs, sb.de, exp_rgb(sb), 8'(exp_addr)));
        // Hand-computed points for the centred window (x0=8, y0=6)
        if (m_x == 8 && m_y == 6 && m_v == 6) begin
          if (m_h == 9)  check("addr_origin", addr_a, 0);
          if (m_h == 16) check("addr_row_end", addr_a, 7);
          if (m_h == 10) check("rgb_background", rgb_a, 8'hA5);
          if (m_h == 18) check("rgb_lat1_pixel", rgb_a, 8'h07);
          if (m_h == 20) check("rgb_lat3_pixel", rgb_b, 8'h07);
          if (m_h == 28) check("hs_before_rise", hs_a, 0);
          if (m_h == 29) check("hs_first_high", hs_a, 1);
        end
        cur.de  = (m_h < HA) && (m_v < VA);
        cur.hs  = (m_h >= HA + HF) && (m_h < HA + HF + HS);
        cur.vs  = (m_v >= VA + VF) && (m_v < VA + VF + VS);
        cur.win = (m_h >= m_x) && (m_h < m_x + PW) && (m_v >= m_y) && (m_v < m_y + PH);
        cur.addr = cur.win ? ((m_v - m_y) * PW + (m_h - m_x)) % 256 : 0;
        q_a.push_back(cur);
        q_b.push_back(cur);
        exp_addr = cur.addr;
        m_keys |= key_pulse;
        m_tog  |= mode_toggle;
        if (bnd) begin
          if (m_auto) begin
            m_x = clampi(m_x + m_dx, 0, XMAX);
            if (m_x == XMAX && m_dx > 0) m_dx = -1;
            else if (m_x == 0 && m_dx < 0) m_dx = 1;
            m_y = clampi(m_y + m_dy, 0, YMAX);
            if (m_y == YMAX && m_dy > 0) m_dy = -1;
            else if (m_y == 0 && m_dy < 0) m_dy = 1;
          end else begin
            if (m_keys[3] != m_keys[2]) m_x = clampi(m_x + (m_keys[3] ? STEP : -STEP), 0, XMAX);
            if (m_keys[1] != m_keys[0]) m_y = clampi(m_y + (m_keys[1] ? STEP : -STEP), 0, YMAX);
          end
          if (m_tog) m_auto = !m_auto;
          m_keys = 4'h0;
          m_tog = 0;
        end
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else m_h++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hv(input int h, input int v);
    bit found = 0;
    for (int i = 0; i <= FRAME && !found; i++) begin
      if (m_h == h && m_v == v) found = 1;
      else step();
    end
    check("wait_hv_reached", found, 1);
  endtask

  task automatic pulse_key(input int h, input int v, input logic [3:0] k);
    wait_hv(h, v);
    key_pulse = k;
    step();
    key_pulse = 4'h0;
  endtask

  task automatic random_frames(input int n);
    for (int i = 0; i < n * FRAME; i++) begin
      key_pulse = ($urandom_range(0, 59) == 0) ? 4'($urandom) : 4'h0;
      step();
    end
    key_pulse = 4'h0;
  endtask

  // Stimulus
  initial begin
    int exp_x[3] = '{14, 16, 16};
    int xmin, xmax, ymin, ymax, fs_cnt;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * FRAME) step();
    check("model_x0_reset", m_x, 8);
    check("model_y0_reset", m_y, 6);

    // Single right pulse mid-frame, applied at the next boundary
    pulse_key(0, 10, 4'b1000);
    check("x0_held_until_boundary", m_x, 8);
    fs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (fs_a) fs_cnt++;
      step();
    end
    check("frame_start_once", fs_cnt, 1);
    check("x0_after_right", m_x, 11);

    // Right pulses over successive frames clamp at the limit
    for (int k = 0; k < 3; k++) begin
      pulse_key(0, 5, 4'b1000);
      wait_hv(1, 0);
      check("x0_right_clamp", m_x, exp_x[k]);
    end

    // Left+right cancel; repeated up pulses count once
    pulse_key(0, 2, 4'b0101);
    pulse_key(0, 8, 4'b1001);
    wait_hv(1, 0);
    check("x0_left_right_cancel", m_x, 16);
    check("y0_up_once", m_y, 3);

    random_frames(10);

    // Auto mode bounces between the edges
    pulse_key(0, 4, 4'b0000);
    mode_toggle = 1'b1;
    step();
    mode_toggle = 1'b0;
    wait_hv(1, 0);
    xmin = m_x; xmax = m_x; ymin = m_y; ymax = m_y;
    for (int i = 0; i < 40 * FRAME; i++) begin
      key_pulse = ($urandom_range(0, 59) == 0) ? 4'($urandom) : 4'h0;
      step();
      if (m_x < xmin) xmin = m_x;
      if (m_x > xmax) xmax = m_x;
      if (m_y < ymin) ymin = m_y;
      if (m_y > ymax) ymax = m_y;
    end
    key_pulse = 4'h0;
    check("auto_x_max", xmax, 16);
    check("auto_x_min", xmin, 0);
    check("auto_y_max", ymax, 12);
    check("auto_y_min", ymin, 0);

    // Back to manual
    pulse_key(0, 4, 4'b0000);
    mode_toggle = 1'b1;
    step();
    mode_toggle = 1'b0;
    random_frames(2);

    // Asynchronous reset in the middle of a frame
    wait_hv(3, 9);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("x0_after_midframe_reset", m_x, 8);
    check("h_after_midframe_reset", m_h, 0);
    repeat (2 * FRAME) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
